// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding and the
// default geometry/latency constants.
package mem_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 9;
    localparam int DEPTH       = 512;
    localparam int WAIT_CYCLES = 2;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word RAM with a registered read port (read-first).
module ram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_unit.sv
// Word-addressed memory responder: latches one read/write request, waits a
// fixed number of cycles, then completes it with a one-cycle Done pulse.
module mem_unit
    import mem_pkg::*;
#(
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int DEPTH       = mem_pkg::DEPTH,
    parameter int WAIT_CYCLES = mem_pkg::WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       mAddr,
    input  logic [DATA_W-1:0] mDataOut,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] mDataIn,
    output logic              Done
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic              done_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^mAddr[31:ADDR_W];

    // The array access (write or registered read) happens on the edge that
    // enters DONE, so its read latency lines up with the DONE cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        mdata_d   = mdata_q;
        ram_we    = 1'b0;
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                ram_addr  = mAddr[ADDR_W-1:0];
                ram_wdata = mDataOut;
                if (Write || Read) begin
                    addr_d  = mAddr[ADDR_W-1:0];
                    wdata_d = mDataOut;
                    is_wr_d = Write;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                        ram_we  = Write;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    ram_we  = is_wr_q;
                end
            end
            ST_DONE: begin
                if (!is_wr_q) begin
                    mdata_d = ram_rdata;
                end
                state_d = (Read || Write) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!Read && !Write) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            mdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            mdata_q <= mdata_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Gating with clr drops any write that would land while reset is held.
    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & clr),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // During a read's DONE cycle the fresh array word is presented directly;
    // mdata_q captures it on the way out and holds it afterwards.
    assign mDataIn = (state_q == ST_DONE && !is_wr_q) ? ram_rdata : mdata_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_mem_unit.sv
// Scoreboard bench for mem_unit: one instance with WAIT_CYCLES=2 (dut_a) and
// one with WAIT_CYCLES=0 (dut_b).
module tb_mem_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_read, a_write, a_done;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_read, b_write, b_done;

    int          vec_n  = 0;
    int          miss_n = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [512];

    always #5 clk = ~clk;

    mem_unit #(.WAIT_CYCLES(2)) dut_a (
        .clk(clk), .clr(clr), .mAddr(a_addr), .mDataOut(a_wdata),
        .Read(a_read), .Write(a_write), .mDataIn(a_rdata), .Done(a_done)
    );

    mem_unit #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .clr(clr), .mAddr(b_addr), .mDataOut(b_wdata),
        .Read(b_read), .Write(b_write), .mDataIn(b_rdata), .Done(b_done)
    );

    // Drives one request, holds it until Done (bounded), drops it in the Done cycle.
    task automatic xfer(input bit sel, input bit wr, input bit rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input bit scramble,
                        output int lat, output logic [31:0] rdata, output bit got);
        @(negedge clk);
        if (sel) begin
            b_addr = addr; b_wdata = data; b_write = wr; b_read = rd;
        end else begin
            a_addr = addr; a_wdata = data; a_write = wr; a_read = rd;
        end
        lat = 0; got = 1'b0; rdata = '0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (scramble && !sel) begin
                a_addr  = addr ^ 32'h1;
                a_wdata = ~data;
            end
            if ((sel ? b_done : a_done) === 1'b1) begin
                got   = 1'b1;
                rdata = sel ? b_rdata : a_rdata;
            end
        end
        if (sel) begin
            b_write = 1'b0; b_read = 1'b0;
        end else begin
            a_write = 1'b0; a_read = 1'b0;
        end
    endtask

    task automatic test_reset();
        int lat; bit got; logic [31:0] rd, exp;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        vec_n++;
        if (a_done !== 1'b0 || b_done !== 1'b0 || a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            miss_n++;
            $display("FAIL reset_state: a_done=%b b_done=%b a_rdata=%h b_rdata=%h want 0", a_done, b_done, a_rdata, b_rdata);
        end
        clr = 1'b1;
        xfer(0, 1, 0, 32'd7, 32'hA5A5_0007, 0, lat, rd, got);
        exp_q.push_back(32'hA5A5_0007);
        xfer(0, 0, 1, 32'd7, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL reset_preload: got=%b data %h want %h", got, rd, exp);
        end
        // Start a write to 7, then pull clr low while it is in BUSY.
        @(negedge clk);
        a_addr = 32'd7; a_wdata = 32'hBAD0_BAD0; a_write = 1'b1;
        @(negedge clk);
        #2 clr = 1'b0;
        #1;
        vec_n++;
        if (a_done !== 1'b0 || a_rdata !== 32'h0) begin
            miss_n++;
            $display("FAIL reset_async: done=%b mDataIn=%h want 0/0", a_done, a_rdata);
        end
        a_write = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        exp_q.push_back(32'hA5A5_0007);
        xfer(0, 0, 1, 32'd7, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL reset_write_dropped: got=%b data %h want %h", got, rd, exp);
        end
    endtask

    task automatic test_write_read();
        int lat; bit got; logic [31:0] rd, exp;
        xfer(0, 1, 0, 32'h1A, 32'hDEAD_BEEF, 0, lat, rd, got);
        vec_n++;
        if (!got || lat != 3) begin
            miss_n++;
            $display("FAIL wr_latency: got=%b lat %0d want 3", got, lat);
        end
        @(negedge clk);
        vec_n++;
        if (a_done !== 1'b0) begin
            miss_n++;
            $display("FAIL wr_done_pulse: Done %b want 0", a_done);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(0, 0, 1, 32'h1A, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || lat != 3 || rd !== exp) begin
            miss_n++;
            $display("FAIL rd_data: got=%b lat %0d data %h want lat 3 data %h", got, lat, rd, exp);
        end
    endtask

    task automatic test_held_request();
        int pulses; logic [31:0] rd, exp; int lat; bit got;
        @(negedge clk);
        a_addr = 32'h1A; a_read = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        pulses = 0; rd = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) begin
                pulses++;
                rd = a_rdata;
            end
        end
        exp = exp_q.pop_front();
        vec_n++;
        if (pulses != 1 || rd !== exp) begin
            miss_n++;
            $display("FAIL held_one_pulse: pulses %0d data %h want 1 and %h", pulses, rd, exp);
        end
        vec_n++;
        if (dut_a.state_q !== ST_HOLD) begin
            miss_n++;
            $display("FAIL held_in_hold: state %0d want %0d", dut_a.state_q, ST_HOLD);
        end
        a_read = 1'b0;
        @(negedge clk);
        vec_n++;
        if (dut_a.state_q !== ST_IDLE) begin
            miss_n++;
            $display("FAIL held_release: state %0d want %0d", dut_a.state_q, ST_IDLE);
        end
        exp_q.push_back(32'hDEAD_BEEF);
        xfer(0, 0, 1, 32'h1A, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || lat != 3 || rd !== exp) begin
            miss_n++;
            $display("FAIL held_next_read: got=%b lat %0d data %h want 3/%h", got, lat, rd, exp);
        end
    endtask

    task automatic test_read_write_both();
        int lat; bit got; logic [31:0] rd, exp;
        xfer(0, 1, 1, 32'd3, 32'h55, 0, lat, rd, got);
        vec_n++;
        if (!got || rd !== 32'hDEAD_BEEF) begin
            miss_n++;
            $display("FAIL both_is_write: got=%b mDataIn %h want %h", got, rd, 32'hDEAD_BEEF);
        end
        exp_q.push_back(32'h55);
        xfer(0, 0, 1, 32'd3, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL both_readback: got=%b data %h want %h", got, rd, exp);
        end
    endtask

    task automatic test_wrap_wait0();
        int lat; bit got; logic [31:0] rd, exp;
        xfer(1, 1, 0, 32'd517, 32'h1234, 0, lat, rd, got);
        vec_n++;
        if (!got || lat != 1) begin
            miss_n++;
            $display("FAIL wait0_wr_latency: got=%b lat %0d want 1", got, lat);
        end
        exp_q.push_back(32'h1234);
        xfer(1, 0, 1, 32'd5, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || lat != 1 || rd !== exp) begin
            miss_n++;
            $display("FAIL wait0_wrap_read: got=%b lat %0d data %h want 1/%h", got, lat, rd, exp);
        end
        xfer(0, 1, 0, 32'h0000_0209, 32'hCAFE_0009, 0, lat, rd, got);
        exp_q.push_back(32'hCAFE_0009);
        xfer(0, 0, 1, 32'd9, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL wait2_wrap_read: got=%b data %h want %h", got, rd, exp);
        end
    endtask

    task automatic test_input_stability();
        int lat; bit got; logic [31:0] rd, exp;
        xfer(0, 1, 0, 32'h41, 32'h3333_3333, 0, lat, rd, got);
        xfer(0, 1, 0, 32'h40, 32'h1111_1111, 1, lat, rd, got);
        exp_q.push_back(32'h1111_1111);
        xfer(0, 0, 1, 32'h40, 32'h0, 1, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL stable_addr_data: got=%b data %h want %h", got, rd, exp);
        end
        exp_q.push_back(32'h3333_3333);
        xfer(0, 0, 1, 32'h41, 32'h0, 0, lat, rd, got);
        exp = exp_q.pop_front();
        vec_n++;
        if (!got || rd !== exp) begin
            miss_n++;
            $display("FAIL stable_neighbor: got=%b data %h want %h", got, rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit got; logic [31:0] rd, exp, a, d;
        for (int i = 0; i < 8; i++) begin
            a = 32'((i * 37 + 100) % 512);
            d = $urandom;
            model[a[8:0]] = d;
            xfer(0, 1, 0, a, d, 0, lat, rd, got);
            vec_n++;
            if (!got || lat != 3) begin
                miss_n++;
                $display("FAIL b2b_write[%0d]: got=%b lat %0d want 3", i, got, lat);
            end
        end
        for (int i = 7; i >= 0; i--) begin
            a = 32'((i * 37 + 100) % 512) + 32'h0001_0000;
            exp_q.push_back(model[a[8:0]]);
            xfer(0, 0, 1, a, 32'h0, 0, lat, rd, got);
            exp = exp_q.pop_front();
            vec_n++;
            if (!got || lat != 3 || rd !== exp) begin
                miss_n++;
                $display("FAIL b2b_read[%0d]: got=%b lat %0d data %h want 3/%h", i, got, lat, rd, exp);
            end
        end
    endtask

    initial begin
        clr = 1'b0;
        a_addr = '0; a_wdata = '0; a_read = 1'b0; a_write = 1'b0;
        b_addr = '0; b_wdata = '0; b_read = 1'b0; b_write = 1'b0;
        test_reset();
        test_write_read();
        test_held_request();
        test_read_write_both();
        test_wrap_wait0();
        test_input_stability();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
